// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DROP, S_HOLD, S_HALT} fetch_state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} fetch_state_t;
`endif

  // One fetched instruction as presented to the F/D pipeline register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetch output buffer: load, consume, flush; empty entry shows NOP.
// Latency: one cycle from load to visible entry.
// Backpressure: holds its entry while the consumer stalls; flush beats load.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  logic       consume,
  input  fetch_ent_t load_ent,
  output logic       valid,
  output fetch_ent_t ent
);

  // Entry register; reset > flush > load > consume, PC fields kept when emptied.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ent   <= {NOP_INSTR, RESET_PC, RESET_PC + 32'd4};
    end else if (flush) begin
      valid     <= 1'b0;
      ent.instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      ent   <= load_ent;
    end else if (consume) begin
      valid     <= 1'b0;
      ent.instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, imem handshake, redirect, one-entry output buffer.
// Latency: imem_rdata to InstrF is one registered cycle; one instr/cycle with 1-cycle memory.
// Backpressure: StallF holds the buffer; a beat arriving while it is full is refetched later.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect sets MisalignF and halts).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic        BusyF,
  output logic        MisalignF
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fpc, fpc_nxt, target;
  logic         buf_load, buf_flush, buf_consume;
  logic         halted;
  fetch_ent_t   buf_ent;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned, misalign_set;
  assign target     = PCTargetE;
  assign misaligned = |PCTargetE[1:0];
  assign halted     = (state == S_HALT);

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)               MisalignF <= 1'b0;
    else if (misalign_set) MisalignF <= 1'b1;
  end
`else
  logic unused_target_lsb;
  assign target            = {PCTargetE[31:2], 2'b00};
  assign unused_target_lsb = ^PCTargetE[1:0];
  assign halted            = 1'b0;
  assign MisalignF         = 1'b0;
`endif

  assign buf_consume = ValidF & ~StallF;
  assign imem_req    = ~rst & ((state == S_REQ) | (state == S_WAIT));
  assign imem_addr   = fpc;
  assign BusyF       = ~ValidF & ~PCSrcE;
  assign InstrF      = buf_ent.instr;
  assign PCF         = buf_ent.pc;
  assign PCPlus4F    = buf_ent.pc4;

  // Next state / PC: redirect wins; a beat is accepted only if the buffer frees up this cycle.
  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_set = 1'b0;
`endif
    if (PCSrcE && !halted) begin
      buf_flush = 1'b1;
      fpc_nxt   = target;
`ifdef FETCH_MISALIGN_CHK_EN
      if (misaligned) begin
        state_nxt    = S_HALT;
        misalign_set = 1'b1;
      end else
`endif
      // A request left unanswered (REQ/WAIT) or a stale beat still owed (DROP) must be eaten.
      if (!imem_ready && (state == S_REQ || state == S_WAIT || state == S_DROP))
        state_nxt = S_DROP;
      else
        state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ, S_WAIT: begin
          if (imem_ready) begin
            if (!ValidF || buf_consume) begin
              buf_load  = 1'b1;
              fpc_nxt   = fpc + 32'd4;
              state_nxt = S_REQ;
            end else begin
              state_nxt = S_HOLD;
            end
          end else begin
            state_nxt = S_WAIT;
          end
        end
        S_DROP:  if (imem_ready)  state_nxt = S_REQ;
        S_HOLD:  if (buf_consume) state_nxt = S_REQ;
        default: state_nxt = state;
      endcase
    end
  end

  // State and fetch PC registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      fpc   <= RESET_PC;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
    end
  end

  fetch_buf #(.RESET_PC(RESET_PC)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .flush    (buf_flush),
    .consume  (buf_consume),
    .load_ent ({imem_rdata, fpc, fpc + 32'd4}),
    .valid    (ValidF),
    .ent      (buf_ent)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect traffic.
// Latency: memory model answers 1..3 cycles after a request is first seen.
// Backpressure: StallF driven randomly; program-order scoreboard on consumed instrs.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidF, BusyF, MisalignF;
  logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;
  logic        r_req, r_valid, r_busy, r_mis;
  logic [31:0] r_addr, r_instr, r_pc, r_pc4;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .ValidF(ValidF), .BusyF(BusyF), .MisalignF(MisalignF)
  );

  fetch_unit #(.RESET_PC(32'h0000_0080)) dut80 (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(r_req), .imem_addr(r_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .InstrF(r_instr), .PCF(r_pc), .PCPlus4F(r_pc4),
    .ValidF(r_valid), .BusyF(r_busy), .MisalignF(r_mis)
  );

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] maddr = '0;
  logic [31:0] exp_pc = '0;
  bit          redir_pending = 0;
  logic [31:0] redir_addr = '0;
  bit          prev_redir = 0;
  bit          m_halt = 0;
  int          consumes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Behavioural expectations for one non-reset cycle.
  task automatic score();
    if (ValidF) begin
      check_eq("instr_vs_pc", InstrF, word(PCF));
      check_eq("pc_plus4", PCPlus4F, PCF + 32'd4);
    end else begin
      check_eq("nop_when_empty", InstrF, NOP);
    end
    check_eq("busy", 32'(BusyF), 32'(!ValidF && !PCSrcE));
    if (prev_redir) check_eq("flush_after_redirect", 32'(ValidF), 32'd0);
    if (m_halt) begin
      check_eq("halt_req", 32'(imem_req), 32'd0);
      check_eq("halt_valid", 32'(ValidF), 32'd0);
      check_eq("halt_misalign", 32'(MisalignF), 32'd1);
    end else begin
      check_eq("misalign_clear", 32'(MisalignF), 32'd0);
    end
    if (redir_pending && imem_req) begin
      check_eq("first_req_addr", imem_addr, redir_addr);
      redir_pending = 0;
    end
    if (ValidF && !StallF && !PCSrcE) begin
      check_eq("program_order", PCF, exp_pc);
      exp_pc = PCF + 32'd4;
      consumes++;
    end
    prev_redir = PCSrcE;
    if (PCSrcE && !m_halt) begin
`ifdef FETCH_MISALIGN_CHK_EN
      if (PCTargetE[1:0] != 2'b00) m_halt = 1;
`endif
      exp_pc        = PCTargetE & 32'hFFFF_FFFC;
      redir_pending = 1;
      redir_addr    = exp_pc;
    end
  endtask

  // One clock cycle: drive inputs, answer memory, then score the settled outputs.
  task automatic cyc(input bit r, input bit s, input bit p, input logic [31:0] t);
    @(negedge clk);
    rst = r; StallF = s; PCSrcE = p; PCTargetE = t;
    #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (!pend && imem_req) begin
      pend = 1; maddr = imem_addr; cnt = 0;
    end else if (pend && imem_req) begin
      check_eq("addr_stable", imem_addr, maddr);
    end
    if (pend) begin
      if (cnt == lat - 1) begin
        imem_ready = 1'b1; imem_rdata = word(maddr); pend = 0;
      end else begin
        cnt++;
      end
    end
    #1;
    if (r) begin
      exp_pc = 32'h0; redir_pending = 1; redir_addr = 32'h0; prev_redir = 0; m_halt = 0;
    end else begin
      score();
    end
  endtask

  task automatic reset_dut(input int l);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    lat = l;
  endtask

  initial begin
    int c0;
    rst = 1; StallF = 0; PCSrcE = 0; PCTargetE = '0; imem_ready = 0; imem_rdata = '0;

    // Reset values, both reset PCs.
    reset_dut(1);
    check_eq("rst_pcf", PCF, 32'h0);
    check_eq("rst_pc4", PCPlus4F, 32'h4);
    check_eq("rst_instr", InstrF, NOP);
    check_eq("rst_valid", 32'(ValidF), 32'd0);
    check_eq("rst_misalign", 32'(MisalignF), 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);

    // Streaming with single-cycle memory, then a 3-cycle stall at PC 8.
    cyc(0, 0, 0, 0); check_eq("s_addr0", imem_addr, 32'h0); check_eq("s_req0", 32'(imem_req), 1);
    cyc(0, 0, 0, 0); check_eq("s_addr1", imem_addr, 32'h4); check_eq("s_pcf1", PCF, 32'h0);
    check_eq("s_valid1", 32'(ValidF), 1);
    cyc(0, 0, 0, 0); check_eq("s_addr2", imem_addr, 32'h8); check_eq("s_pcf2", PCF, 32'h4);
    cyc(0, 1, 0, 0); check_eq("s_addr3", imem_addr, 32'hC); check_eq("s_pcf3", PCF, 32'h8);
    check_eq("s_valid3", 32'(ValidF), 1);
    cyc(0, 1, 0, 0); check_eq("stall_pcf4", PCF, 32'h8); check_eq("stall_req4", 32'(imem_req), 0);
    cyc(0, 1, 0, 0); check_eq("stall_pcf5", PCF, 32'h8); check_eq("stall_req5", 32'(imem_req), 0);
    cyc(0, 0, 0, 0); check_eq("stall_pcf6", PCF, 32'h8); check_eq("stall_req6", 32'(imem_req), 0);
    cyc(0, 0, 0, 0); check_eq("resume_addr", imem_addr, 32'hC); check_eq("resume_req", 32'(imem_req), 1);

    // Redirect to 0x100 while waiting on a 3-cycle memory.
    reset_dut(3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0); check_eq("drop_req", 32'(imem_req), 0); check_eq("drop_valid", 32'(ValidF), 0);
    cyc(0, 0, 0, 0); check_eq("drop_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); check_eq("drop_pcf", PCF, 32'h100); check_eq("drop_valid2", 32'(ValidF), 1);

    // Redirect to 0x40 coinciding with a ready beat.
    reset_dut(1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40);
    check_eq("rr_ready", 32'(imem_ready), 1);
    cyc(0, 0, 0, 0); check_eq("rr_valid", 32'(ValidF), 0); check_eq("rr_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 0); check_eq("rr_pcf", PCF, 32'h40);

    // Misaligned redirect target.
    reset_dut(1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
    cyc(0, 0, 0, 0); check_eq("mis_flag", 32'(MisalignF), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, (i == 1), 32'h200);
      check_eq("mis_req", 32'(imem_req), 0);
    end
    reset_dut(1);
    check_eq("mis_cleared", 32'(MisalignF), 0);
`else
    cyc(0, 0, 0, 0); check_eq("mis_addr", imem_addr, 32'h100); check_eq("mis_flag", 32'(MisalignF), 0);
`endif

    // Reset pulsed while waiting; instance with RESET_PC 0x80.
    reset_dut(3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset_dut(3);
    check_eq("r80_addr", r_addr, 32'h80);
    check_eq("r80_pcf", r_pc, 32'h80);
    check_eq("r80_pc4", r_pc4, 32'h84);
    check_eq("r80_instr", r_instr, NOP);
    check_eq("r80_valid", 32'(r_valid), 0);
    check_eq("r80_mis", 32'(r_mis), 0);
    check_eq("r80_busy", 32'(r_busy), 1);
    cyc(0, 0, 0, 0);
    check_eq("r80_first_req", 32'(r_req), 1);
    check_eq("r80_first_addr", r_addr, 32'h80);

    // Address wrap at the top of the space.
    reset_dut(1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    check_eq("wrap_pcf", PCF, 32'h0);

    // Randomized traffic.
    for (int ph = 0; ph < 6; ph++) begin
      reset_dut($urandom_range(1, 3));
      c0 = consumes;
      for (int i = 0; i < 150; i++)
        cyc(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            $urandom & 32'h0000_3FFC);
      check_eq("progress", 32'(consumes - c0 >= 10), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 StallF  input  1  hazard-unit stall; output buffer held, no consumption.
REQ-005 PCSrcE  input  1  redirect request from EX (taken branch/jump).
REQ-006 PCTargetE  input  32  redirect target address.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  fetch address, equal to internal fetch PC.
REQ-009 imem_ready  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 InstrF, PCF, PCPlus4F  output  32 each  buffered instruction, its address, address+4; feed the F/D pipeline register.
REQ-012 ValidF  output  1  output buffer holds a real instruction; when 0, InstrF SHALL be NOP 32'h0000_0013.
REQ-013 BusyF  output  1  high when ValidF=0 and no redirect this cycle; hazard unit uses it to bubble decode.
REQ-014 MisalignF  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-015 The state machine SHALL have states REQ, WAIT, DROP, HOLD, with HALT added only when the misalignment macro is defined.
REQ-016 imem_req SHALL be 1 in REQ and WAIT, and 0 in DROP, HOLD and HALT.
REQ-017 REQ/WAIT with imem_ready=1, no redirect: buffer <= {imem_rdata, fpc, fpc+4}; ValidF<=1; fpc<=fpc+4; next state REQ if buffer consumed or empty this cycle, else HOLD.
REQ-018 REQ with imem_ready=0 SHALL move to WAIT; imem_addr SHALL stay stable until imem_ready.
REQ-019 The buffer SHALL be consumed in any cycle with ValidF=1 and StallF=0; after consumption with no new fill, ValidF SHALL be 0 next cycle.
REQ-020 HOLD SHALL move to REQ on the cycle the buffer is consumed.
REQ-021 PCSrcE=1 SHALL take priority over StallF and imem_ready: fpc<=PCTargetE, ValidF<=0 next cycle, and the buffer SHALL be discarded.
REQ-022 Redirect in WAIT with imem_ready=0 SHALL go to DROP; DROP SHALL discard the next imem_ready beat and then go to REQ.
REQ-023 Redirect coinciding with imem_ready SHALL discard imem_rdata, and REQ SHALL issue PCTargetE on the next cycle.
REQ-024 Arithmetic SHALL be 32-bit unsigned; fpc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-025 The path from imem_rdata to InstrF SHALL be one registered cycle; best-case throughput SHALL be one instruction per cycle with single-cycle memory.

Reset
REQ-026 When rst=1 at a clock edge: fpc=RESET_PC, PCF=RESET_PC, PCPlus4F=RESET_PC+4, InstrF=NOP, ValidF=0, MisalignF=0, state=REQ.
REQ-027 Reset SHALL override redirect, stall and imem_ready in the same cycle.
REQ-028 Any in-flight memory beat arriving after reset SHALL be ignored when it lands while rst=1.
REQ-029 After rst deasserts, the first request SHALL be issued in the following cycle.

Configuration
REQ-030 With FETCH_MISALIGN_CHK_EN defined:
- A redirect with PCTargetE[1:0]!=0 SHALL set MisalignF=1 and enter HALT.
- HALT SHALL hold imem_req=0 and ValidF=0.
- Only rst SHALL exit HALT.
REQ-031 With FETCH_MISALIGN_CHK_EN undefined:
- PCTargetE[1:0] SHALL be forced to 2'b00.
- MisalignF SHALL be tied 0.
- HALT SHALL not exist.

Structure
REQ-032 A shared package SHALL hold the state enum, the NOP constant 32'h0000_0013 and the RESET_PC default.
REQ-033 A single sub-module, fetch_buf, SHALL implement the one-entry output buffer (load, consume, flush); the state machine and PC logic SHALL stay in fetch_unit.

Verification
REQ-034 Reset, then single-cycle memory, no stalls: imem_addr SHALL be 0,4,8,12; PCF 0,4,8 on consecutive cycles; ValidF=1 from cycle 2.
REQ-035 StallF=1 for 3 cycles with buffer full at PC 8: PCF SHALL hold 8, the state SHALL be HOLD, imem_req=0; one cycle after StallF drops, imem_addr SHALL be 12.
REQ-036 Memory latency 3, PCSrcE=1 with target 0x100 in WAIT: the stale beat SHALL be dropped; imem_addr=0x100 next; PCF=0x100 with ValidF=1 after the next ready.
REQ-037 PCSrcE=1 with target 0x40 and imem_ready=1 in the same cycle: the old data SHALL be discarded, ValidF=0 next cycle, imem_addr=0x40.
REQ-038 With the macro defined, redirect to 0x102: MisalignF=1, imem_req=0 until rst; with the macro undefined, imem_addr SHALL be 0x100.
REQ-039 rst pulsed while in WAIT with RESET_PC=0x80: all outputs SHALL match REQ-026 and imem_addr SHALL be 0x80.
